product_accumulator: RTL

//  Consumes the 8-bit product stream from the 4x4 array multiplier and sums N_TERMS

---
 rtl/product_accumulator_pkg.sv | 25 ++
 rtl/product_accumulator_term_counter.sv | 50 +++++
 rtl/product_accumulator.sv | 113 +++++++++++
 3 files changed

// File: rtl/product_accumulator_pkg.sv
// Shared definitions for the product accumulator.
//   - FSM state encoding (the unused code 2'd3 is treated as a recovery state).
//   - Default parameter values for the stage.
//   - A small helper that says whether a state may take products.
package product_accumulator_pkg;

    // Default datapath sizes, matched to the 4x4 array multiplier upstream.
    localparam int unsigned PW_DEF      = 8;
    localparam int unsigned N_TERMS_DEF = 4;
    localparam int unsigned ACC_W_DEF   = 16;
    localparam int unsigned CNT_W_DEF   = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,  // no terms held
        StAccum = 2'd1,  // at least one term held
        StDone  = 2'd2   // result held, waiting for the downstream handshake
    } state_e;

    // Only IDLE and ACCUM take products. The illegal code is excluded so a corrupted state
    // can never absorb a term before it recovers.
    function automatic logic state_takes_terms(input state_e st);
        return (st == StIdle) || (st == StAccum);
    endfunction

endpackage

// File: rtl/product_accumulator_term_counter.sv
// Term counter for the product accumulator.
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous reset, active-high
//   clr    in   1      synchronous clear to zero (wins over inc)
//   inc    in   1      count one accepted term
//   count  out  CNT_W  terms counted so far
//   hit    out  1      the next increment reaches N_TERMS (count+1 == N_TERMS)
module product_accumulator_term_counter
    import product_accumulator_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned N_TERMS = N_TERMS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             hit
);

    // Compare one bit wider so that count+1 never wraps before the compare.
    localparam logic [CNT_W:0] LastTerm = (CNT_W + 1)'(N_TERMS);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W:0]   count_inc;

    always_comb begin
        count_inc = {1'b0, count_q} + {{CNT_W{1'b0}}, 1'b1};
        count_d   = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_inc[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign hit   = (count_inc == LastTerm);

endmodule

// File: rtl/product_accumulator.sv
// Dot-product stage of the multiply datapath: sums N_TERMS unsigned products (or fewer, when
// a term arrives with prod_last) and presents the sum on a valid/ready output.
//   clk         in   1      rising-edge clock
//   rst         in   1      synchronous reset, active-high (dominates clear)
//   clear       in   1      synchronous abort, drops any partial or pending result
//   prod_valid  in   1      product available
//   prod_ready  out  1      accumulator can take a product
//   prod_data   in   PW     unsigned product
//   prod_last   in   1      prod_data is the final term of this result
//   acc_valid   out  1      result available
//   acc_ready   in   1      downstream takes the result
//   acc_data    out  ACC_W  unsigned sum, 0 outside DONE
//   acc_count   out  CNT_W  terms in acc_data, 0 outside DONE
//   acc_ovf     out  1      sum wrapped past 2^ACC_W-1 during this result, 0 outside DONE
// All acc_* outputs come from registers only; prod_* never reaches them combinationally.
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int unsigned PW      = PW_DEF,
    parameter int unsigned N_TERMS = N_TERMS_DEF,
    parameter int unsigned ACC_W   = ACC_W_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             prod_valid,
    output logic             prod_ready,
    input  logic [PW-1:0]    prod_data,
    input  logic             prod_last,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic [ACC_W-1:0] acc_data,
    output logic [CNT_W-1:0] acc_count,
    output logic             acc_ovf
);

    state_e           state_q;
    logic [ACC_W-1:0] acc_q;
    logic             ovf_q;

    logic             accept;
    logic             release_result;
    logic             cnt_clr;
    logic             cnt_hit;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W:0]   sum;

    // No bypass: a held result blocks the input until it has been taken.
    assign prod_ready     = !rst && !clear && state_takes_terms(state_q);
    assign accept         = prod_valid && prod_ready;
    assign release_result = (state_q == StDone) && acc_ready;

    // Zero-extend both operands one bit past the accumulator so the top bit is the carry.
    assign sum = {1'b0, acc_q} + {{(ACC_W + 1 - PW){1'b0}}, prod_data};

    // The counter is zeroed wherever the accumulator is: abort, handoff, or illegal state.
    assign cnt_clr = clear || release_result ||
                     ((state_q != StIdle) && (state_q != StAccum) && (state_q != StDone));

    product_accumulator_term_counter #(
        .CNT_W   (CNT_W),
        .N_TERMS (N_TERMS)
    ) u_term_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (accept),
        .count (cnt),
        .hit   (cnt_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else if (clear) begin
            state_q <= StIdle;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StAccum: begin
                    if (accept) begin
                        acc_q   <= sum[ACC_W-1:0];
                        ovf_q   <= ovf_q | sum[ACC_W];
                        state_q <= (cnt_hit || prod_last) ? StDone : StAccum;
                    end
                end
                StDone: begin
                    if (acc_ready) begin
                        state_q <= StIdle;
                        acc_q   <= '0;
                        ovf_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    acc_q   <= '0;
                    ovf_q   <= 1'b0;
                end
            endcase
        end
    end

    // Outputs are gated by the registered state so partial sums are never visible.
    assign acc_valid = (state_q == StDone);
    assign acc_data  = acc_valid ? acc_q : '0;
    assign acc_count = acc_valid ? cnt : '0;
    assign acc_ovf   = acc_valid && ovf_q;

endmodule
